// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the X/Y/Z register sequencing controller: instruction
// codes, opcodes, ALU selects, FSM states and the per-state output decode.
package reg_ctrl_pkg;

   localparam logic [2:0] INSTR_HOLD   = 3'b000;
   localparam logic [2:0] INSTR_LOAD   = 3'b001;
   localparam logic [2:0] INSTR_SHIFTR = 3'b010;
   localparam logic [2:0] INSTR_SHIFTL = 3'b011;
   localparam logic [2:0] INSTR_RESET  = 3'b100;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_CLR   = 3'b001;
   localparam logic [2:0] OP_LDX   = 3'b010;
   localparam logic [2:0] OP_MOVXY = 3'b011;
   localparam logic [2:0] OP_ADD   = 3'b100;
   localparam logic [2:0] OP_SUB   = 3'b101;
   localparam logic [2:0] OP_SHL   = 3'b110;
   localparam logic [2:0] OP_SHR   = 3'b111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EXEC1 = 3'd1,
      ST_EXEC2 = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic [2:0] instr_x;
      logic [2:0] instr_y;
      logic [2:0] instr_z;
      logic [1:0] alu_sel;
      logic       busy;
      logic       done;
   } ctrl_t;

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR);
   endfunction

   // Moore decode: what the datapath sees while sitting in state st.
   function automatic ctrl_t step_ctrl(input state_t st, input logic [2:0] op);
      ctrl_t c;
      c.instr_x = INSTR_HOLD;
      c.instr_y = INSTR_HOLD;
      c.instr_z = INSTR_HOLD;
      c.alu_sel = ALU_ADD;
      c.busy    = (st != ST_IDLE);
      c.done    = (st == ST_DONE);
      case (st)
         ST_EXEC1: begin
            case (op)
               OP_CLR: begin
                  c.instr_x = INSTR_RESET;
                  c.instr_y = INSTR_RESET;
                  c.instr_z = INSTR_RESET;
               end
               OP_LDX:   c.instr_x = INSTR_LOAD;
               OP_MOVXY: c.instr_y = INSTR_LOAD;
               OP_ADD:   c.instr_y = INSTR_LOAD;
               OP_SUB: begin
                  c.instr_y = INSTR_LOAD;
                  c.alu_sel = ALU_SUB;
               end
               OP_SHL:   c.instr_z = INSTR_SHIFTL;
               OP_SHR:   c.instr_z = INSTR_SHIFTR;
               default: ;
            endcase
         end
         ST_EXEC2: begin
            c.instr_z = INSTR_LOAD;
            c.alu_sel = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
         end
         ST_SHIFT: c.instr_z = (op == OP_SHR) ? INSTR_SHIFTR : INSTR_SHIFTL;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter tracking the remaining shift steps; load wins over
// decrement and the count never wraps below zero.
module step_counter #(
   parameter int W = 3
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/register_control_unit.sv
// Sequencing controller: accepts one opcode per start handshake and steps the
// X/Y/Z instruction lines and ALU select through the operation's execute steps.
module register_control_unit
   import reg_ctrl_pkg::*;
#(
   parameter int SHW = 3
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [2:0]     opcode,
   input  logic [SHW-1:0] shamt,
   output logic [2:0]     instrX,
   output logic [2:0]     instrY,
   output logic [2:0]     instrZ,
   output logic [1:0]     aluSel,
   output logic           busy,
   output logic           done
);

   state_t         state_reg, state_next;
   logic [2:0]     op_reg, op_next;
   logic [SHW-1:0] shamt_reg, shamt_next;
   ctrl_t          ctrl_reg;

   logic           cnt_load;
   logic           cnt_dec;
   logic [SHW-1:0] cnt_value;
   logic           cnt_zero;

   // EXEC1 performs the first shift itself, so SHIFT only covers the remaining shamt-1.
   assign cnt_load = (state_reg == ST_EXEC1) && is_shift(op_reg) && (shamt_reg > SHW'(1));
   assign cnt_dec  = (state_reg == ST_SHIFT);

   step_counter #(
      .W(SHW)
   ) u_step_counter (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (cnt_load),
      .dec        (cnt_dec),
      .load_value (shamt_reg - SHW'(1)),
      .count      (cnt_value),
      .zero       (cnt_zero)
   );

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      shamt_next = shamt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               op_next    = opcode;
               shamt_next = shamt;
               state_next = (is_shift(opcode) && (shamt == '0)) ? ST_DONE : ST_EXEC1;
            end
         end
         ST_EXEC1: begin
            if ((op_reg == OP_ADD) || (op_reg == OP_SUB))
               state_next = ST_EXEC2;
            else if (is_shift(op_reg) && (shamt_reg > SHW'(1)))
               state_next = ST_SHIFT;
            else
               state_next = ST_DONE;
         end
         ST_EXEC2: state_next = ST_DONE;
         ST_SHIFT: begin
            // The decrement taking place this cycle brings the count to zero.
            if (cnt_zero || (cnt_value == SHW'(1)))
               state_next = ST_DONE;
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs are registered alongside the state so they are glitch-free Moore values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         op_reg    <= OP_NOP;
         shamt_reg <= '0;
         ctrl_reg  <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         shamt_reg <= shamt_next;
         ctrl_reg  <= step_ctrl(state_next, op_next);
      end
   end

   assign instrX = ctrl_reg.instr_x;
   assign instrY = ctrl_reg.instr_y;
   assign instrZ = ctrl_reg.instr_z;
   assign aluSel = ctrl_reg.alu_sel;
   assign busy   = ctrl_reg.busy;
   assign done   = ctrl_reg.done;

endmodule
